// File: rtl/gap_fill_pkg.sv
// Shared types and constants for the gap-fill arbiter slice.
package gap_fill_pkg;

    localparam int       GF_W    = 6;
    localparam bit [2:0] PATTERN = 3'b101;

    typedef logic [GF_W-1:0] gf_word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/gap_fill_core.sv
// Combinational gap fill: any 0 with 1s on both sides is set, MSB-first,
// each window seeing the result of the windows above it.
module gap_fill_core
    import gap_fill_pkg::*;
(
    input  gf_word_t din,
    output gf_word_t dout,
    output logic     changed
);

    gf_word_t w;

    always_comb begin
        w = din;
        for (int i = GF_W - 1; i >= 2; i--) begin
            if (w[i -: 3] == PATTERN) begin
                w[i-1] = 1'b1;
            end
        end
    end

    assign dout    = w;
    assign changed = (w != din);

endmodule

// File: rtl/gap_fill_arbiter.sv
// Two-requester round-robin front end for one shared gap-fill unit, with a
// registered result stage. Statistics counters exist only with GAP_FILL_ARB_STATS_EN.
module gap_fill_arbiter
    import gap_fill_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int DATA_W = GF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              out_changed,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_changed
);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       can_load;
    logic       any_req;
    logic       grant;
    logic       hs;
    gf_word_t   fill_in;
    gf_word_t   fill_out;
    logic       fill_changed;

    assign can_load = (state == EMPTY) || out_ready;
    assign any_req  = req0_valid || req1_valid;

    // Contested cycles go to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign hs      = can_load && any_req;
    assign fill_in = grant ? req1_data : req0_data;

    gap_fill_core u_core (
        .din     (fill_in),
        .dout    (fill_out),
        .changed (fill_changed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (hs) begin
                last_grant <= grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (hs) state_nxt = FULL;
            FULL:  if (out_ready && !hs) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        out_valid  = (state == FULL);
        if (hs) begin
            req0_ready = ~grant;
            req1_ready = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_id      <= 1'b0;
            out_changed <= 1'b0;
        end else if (hs) begin
            out_data    <= fill_out;
            out_id      <= grant;
            out_changed <= fill_changed;
        end
    end

`ifdef GAP_FILL_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words   <= '0;
            stat_changed <= '0;
        end else if (hs) begin
            if (!(&stat_words)) begin
                stat_words <= stat_words + CNT_W'(1);
            end
            if (fill_changed && !(&stat_changed)) begin
                stat_changed <= stat_changed + CNT_W'(1);
            end
        end
    end
`else
    assign stat_words   = '0;
    assign stat_changed = '0;
`endif

endmodule
